// File: rtl/es_nios2_qsys_0_oci_dct_pkg.sv
// rtl/es_nios2_qsys_0_oci_dct_pkg.sv - shared DCT trace widths, atom codes and packer states
package es_nios2_qsys_0_oci_dct_pkg;

  localparam int DCT_ATOM_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_CNT_W  = 4;

  localparam logic [1:0] DCT_NONE      = 2'b00;
  localparam logic [1:0] DCT_TAKEN     = 2'b01;
  localparam logic [1:0] DCT_NOT_TAKEN = 2'b10;
  localparam logic [1:0] DCT_INDIRECT  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_ACCUM      = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } dct_state_e;

endpackage

// File: rtl/es_nios2_qsys_0_oci_dct_outreg.sv
// rtl/es_nios2_qsys_0_oci_dct_outreg.sv - one-entry valid/ready frame register for OCI trace producers
module es_nios2_qsys_0_oci_dct_outreg #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic [CNT_W-1:0]  i_load_cnt,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  // Free when empty or being drained this cycle, so a reload can follow with no bubble.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_load && o_free) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
      r_cnt   <= i_load_cnt;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/es_nios2_qsys_0_oci_dct_packer.sv
// rtl/es_nios2_qsys_0_oci_dct_packer.sv - packs DCT atoms into 15-slot frames with flush support
module es_nios2_qsys_0_oci_dct_packer
  import es_nios2_qsys_0_oci_dct_pkg::*;
#(
  parameter int ATOM_W = DCT_ATOM_W,
  parameter int SLOTS  = DCT_SLOTS,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_atom_valid,
  input  logic [ATOM_W-1:0]       i_atom_data,
  output logic                    o_atom_ready,
  input  logic                    i_flush,
  output logic                    o_dct_valid,
  input  logic                    i_dct_ready,
  output logic [ATOM_W*SLOTS-1:0] o_dct_buffer,
  output logic [CNT_W-1:0]        o_dct_count
);

  localparam int BUF_W = ATOM_W * SLOTS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  dct_state_e       r_state, w_state_nxt;
  logic [BUF_W-1:0] r_acc_buf, w_acc_buf_nxt, w_shifted, w_load_data;
  logic [CNT_W-1:0] r_acc_cnt, w_acc_cnt_nxt, w_load_cnt;
  logic             w_flush_pend, w_out_free, w_accept, w_full;
  logic             w_flush_emit, w_empty_flush, w_load;

  assign w_flush_pend  = (r_state == ST_FLUSH_PEND);
  assign o_atom_ready  = !i_reset && !w_flush_pend && ((r_acc_cnt != LAST_CNT) || w_out_free);
  assign w_accept      = i_atom_valid && o_atom_ready;
  assign w_shifted     = {r_acc_buf[BUF_W-ATOM_W-1:0], i_atom_data};
  assign w_full        = w_accept && (r_acc_cnt == LAST_CNT);
  assign w_flush_emit  = w_flush_pend && (r_acc_cnt != '0) && w_out_free;
  assign w_empty_flush = w_flush_pend && (r_acc_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_buf_nxt = r_acc_buf;
    w_acc_cnt_nxt = r_acc_cnt;
    w_load        = 1'b0;
    w_load_data   = w_shifted;
    w_load_cnt    = FULL_CNT;

    // A full emit and a flush emit never coincide: atoms are refused while a flush is pending.
    if (w_full) begin
      w_load        = 1'b1;
      w_acc_buf_nxt = '0;
      w_acc_cnt_nxt = '0;
    end else if (w_flush_emit) begin
      w_load        = 1'b1;
      w_load_data   = r_acc_buf;
      w_load_cnt    = r_acc_cnt;
      w_acc_buf_nxt = '0;
      w_acc_cnt_nxt = '0;
    end else if (w_accept) begin
      w_acc_buf_nxt = w_shifted;
      w_acc_cnt_nxt = r_acc_cnt + CNT_W'(1);
    end

    case (r_state)
      ST_EMPTY: begin
        if (w_full)        w_state_nxt = ST_EMPTY;
        else if (i_flush)  w_state_nxt = ST_FLUSH_PEND;
        else if (w_accept) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        // The 15th atom closes the frame itself, so a same-cycle flush has nothing left to do.
        if (w_full)       w_state_nxt = ST_EMPTY;
        else if (i_flush) w_state_nxt = ST_FLUSH_PEND;
      end
      ST_FLUSH_PEND: begin
        if (w_flush_emit || w_empty_flush) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_EMPTY;
      r_acc_buf <= '0;
      r_acc_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc_buf <= w_acc_buf_nxt;
      r_acc_cnt <= w_acc_cnt_nxt;
    end
  end

  es_nios2_qsys_0_oci_dct_outreg #(
    .DATA_W (BUF_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_load_cnt  (w_load_cnt),
    .i_ready     (i_dct_ready),
    .o_valid     (o_dct_valid),
    .o_data      (o_dct_buffer),
    .o_cnt       (o_dct_count),
    .o_free      (w_out_free)
  );

endmodule

// File: tb/tb_es_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_es_nios2_qsys_0_oci_dct_packer.sv - directed scoreboard bench for the DCT packer
module tb_es_nios2_qsys_0_oci_dct_packer;
  import es_nios2_qsys_0_oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset, atom_valid, flush, dct_ready;
  logic [1:0]  atom_data;
  logic        atom_ready, dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  typedef struct packed {
    logic [29:0] b;
    logic [3:0]  c;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      mon_f;
  logic [29:0] m_buf;
  int          m_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          frames_seen = 0;

  always #5 clk = ~clk;

  es_nios2_qsys_0_oci_dct_packer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_atom_valid (atom_valid),
    .i_atom_data  (atom_data),
    .o_atom_ready (atom_ready),
    .i_flush      (flush),
    .o_dct_valid  (dct_valid),
    .i_dct_ready  (dct_ready),
    .o_dct_buffer (dct_buffer),
    .o_dct_count  (dct_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_atom(input logic [1:0] d);
    m_buf = {m_buf[27:0], d};
    m_cnt++;
    if (m_cnt == 15) begin
      exp_q.push_back(frame_t'({m_buf, 4'd15}));
      m_buf = '0;
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    if (m_cnt > 0) begin
      exp_q.push_back(frame_t'({m_buf, 4'(m_cnt)}));
      m_buf = '0;
      m_cnt = 0;
    end
  endtask

  // Drives one atom (optionally with flush) and holds it until accepted.
  task automatic send(input logic [1:0] d, input logic fl);
    int guard;
    guard = 0;
    atom_valid = 1'b1;
    atom_data  = d;
    flush      = fl;
    @(negedge clk);
    while (!atom_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("send_accept_bound", 64'(guard < 100), 64'd1);
    model_atom(d);
    if (fl) model_flush();
    @(posedge clk); #1;
    atom_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: every transferred frame must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && dct_valid && dct_ready) begin
      frames_seen++;
      chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_f = exp_q.pop_front();
        chk("sb_buffer", 64'(dct_buffer), 64'(mon_f.b));
        chk("sb_count", 64'(dct_count), 64'(mon_f.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0, acc;
    logic held_have, held_ok;
    frame_t held;

    reset = 1'b1; atom_valid = 1'b0; flush = 1'b0; dct_ready = 1'b1; atom_data = 2'b00;
    m_buf = '0; m_cnt = 0;
    idle(2);
    @(negedge clk);
    chk("rst_atom_ready", 64'(atom_ready), 64'd0);
    chk("rst_dct_valid", 64'(dct_valid), 64'd0);
    chk("rst_dct_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_dct_count", 64'(dct_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_atom_ready", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;

    // Full frame of 15 TAKEN atoms
    fs0 = frames_seen;
    for (int i = 0; i < 15; i++) send(DCT_TAKEN, 1'b0);
    @(negedge clk);
    chk("full_valid", 64'(dct_valid), 64'd1);
    chk("full_count", 64'(dct_count), 64'd15);
    chk("full_buffer", 64'(dct_buffer), 64'h15555555);
    @(negedge clk);
    chk("full_valid_one_cycle", 64'(dct_valid), 64'd0);
    chk("full_frames", 64'(frames_seen - fs0), 64'd1);
    @(posedge clk); #1;

    // Flush of a 3-atom partial frame
    send(DCT_INDIRECT, 1'b0);
    send(DCT_NOT_TAKEN, 1'b0);
    send(DCT_TAKEN, 1'b0);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    chk("flush_c0_ready", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_c1_ready", 64'(atom_ready), 64'd0);
    chk("flush_c1_valid", 64'(dct_valid), 64'd0);
    @(negedge clk);
    chk("flush_c2_valid", 64'(dct_valid), 64'd1);
    chk("flush_c2_count", 64'(dct_count), 64'd3);
    chk("flush_c2_buffer", 64'(dct_buffer), 64'h39);
    chk("flush_c2_ready", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;

    // Backpressure: stalled sink, 29 acceptances then atom_ready drops
    dct_ready = 1'b0;
    acc = 0; held_have = 1'b0; held_ok = 1'b1; held = '0;
    atom_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      atom_data = 2'((acc * 3 + 1) % 4);
      @(negedge clk);
      if (held_have) begin
        if (!dct_valid || frame_t'({dct_buffer, dct_count}) != held) held_ok = 1'b0;
      end else if (dct_valid) begin
        held_have = 1'b1;
        held = frame_t'({dct_buffer, dct_count});
      end
      if (atom_ready) begin
        model_atom(atom_data);
        acc++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc), 64'd29);
    chk("bp_held_stable", 64'(held_ok && held_have), 64'd1);
    atom_data = 2'((acc * 3 + 1) % 4);
    @(negedge clk);
    chk("bp_stalled_ready", 64'(atom_ready), 64'd0);
    chk("bp_stalled_valid", 64'(dct_valid), 64'd1);
    @(posedge clk); #1;
    fs0 = frames_seen;
    dct_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(atom_ready), 64'd1);
    if (atom_ready) model_atom(atom_data);
    @(posedge clk); #1;
    atom_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 64'(dct_valid), 64'd1);
    chk("bp_second_count", 64'(dct_count), 64'd15);
    @(posedge clk); #1;
    chk("bp_two_frames", 64'(frames_seen - fs0), 64'd2);

    // 15th atom together with flush: one full frame only
    fs0 = frames_seen;
    for (int i = 0; i < 14; i++) send(DCT_NOT_TAKEN, 1'b0);
    send(DCT_INDIRECT, 1'b1);
    @(negedge clk);
    chk("af_valid", 64'(dct_valid), 64'd1);
    chk("af_count", 64'(dct_count), 64'd15);
    idle(4);
    chk("af_one_frame", 64'(frames_seen - fs0), 64'd1);
    @(negedge clk);
    chk("af_ready_after", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;

    // Empty flush: no frame
    fs0 = frames_seen;
    flush = 1'b1;
    model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("ef_pend_ready", 64'(atom_ready), 64'd0);
    idle(4);
    chk("ef_no_frame", 64'(frames_seen - fs0), 64'd0);
    @(negedge clk);
    chk("ef_ready_after", 64'(atom_ready), 64'd1);
    @(posedge clk); #1;

    // Reset with a held frame and 7 atoms accumulated
    dct_ready = 1'b0;
    for (int i = 0; i < 22; i++) send(DCT_NONE, 1'b0);
    @(negedge clk);
    chk("mr_held_valid", 64'(dct_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rst_ready", 64'(atom_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_buf = '0; m_cnt = 0;
    @(negedge clk);
    chk("mr_valid", 64'(dct_valid), 64'd0);
    chk("mr_count", 64'(dct_count), 64'd0);
    @(posedge clk); #1;
    dct_ready = 1'b1;
    fs0 = frames_seen;
    for (int i = 0; i < 15; i++) send(2'(i + 1), 1'b0);
    idle(3);
    chk("mr_new_frame", 64'(frames_seen - fs0), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
